// File: rtl/i2s_capture_ctrl.sv
// Sequencer for the I2S clock generator and capture path: releases the generator on start,
// drops warm-up frames, gates capture for a frame count or until stop, and flags a stalled frame pulse.
module i2s_capture_ctrl #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned WARMUP_FRAMES = 16,
    parameter int unsigned TIMEOUT_CYC   = 65536
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [CNT_W-1:0] start_frames_i,
    input  logic             stop_i,
    input  logic             frame_start_i,
    output logic             gen_rst_no,
    output logic             capture_en_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    localparam int unsigned WRM_W = $clog2(WARMUP_FRAMES + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'(WARMUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [WRM_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic               gen_rst_n_q, gen_rst_n_d;
    logic               capture_en_q, capture_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic               tmo_hit;
    logic               exit_now;

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            frame_cnt_q  <= '0;
            warm_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            stop_pend_q  <= 1'b0;
            gen_rst_n_q  <= 1'b0;
            capture_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            frame_cnt_q  <= frame_cnt_d;
            warm_cnt_q   <= warm_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            stop_pend_q  <= stop_pend_d;
            gen_rst_n_q  <= gen_rst_n_d;
            capture_en_q <= capture_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        frame_cnt_d = frame_cnt_q;
        warm_cnt_d  = warm_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        stop_pend_d = stop_pend_q;
        err_d       = err_q;
        done_d      = 1'b0;
        exit_now    = 1'b0;

        cnt_inc = (frame_cnt_q == CNT_MAX) ? frame_cnt_q : frame_cnt_q + CNT_W'(1);
        tmo_hit = !frame_start_i && (tmo_cnt_q == TMO_LAST);

        if (state_q != ST_IDLE) begin
            tmo_cnt_d = frame_start_i ? '0 : tmo_cnt_q + TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_valid_i) begin
                    state_d     = ST_WARMUP;
                    target_d    = start_frames_i;
                    frame_cnt_d = '0;
                    warm_cnt_d  = '0;
                    tmo_cnt_d   = '0;
                    err_d       = 1'b0;
                end
            end
            ST_WARMUP: begin
                if (stop_i) begin
                    exit_now = 1'b1;
                end else if (frame_start_i) begin
                    warm_cnt_d = warm_cnt_q + WRM_W'(1);
                    if (warm_cnt_q == WRM_LAST) begin
                        state_d = ST_CAPTURE;
                    end
                end else if (tmo_hit) begin
                    exit_now = 1'b1;
                    err_d    = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (frame_start_i) begin
                    frame_cnt_d = cnt_inc;
                    if (((target_q != '0) && (cnt_inc == target_q)) || stop_pend_q || stop_i) begin
                        exit_now = 1'b1;
                    end
                end else begin
                    if (stop_i) begin
                        stop_pend_d = 1'b1;
                    end
                    if (tmo_hit) begin
                        exit_now = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (exit_now) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
        end

        busy_d       = (state_d != ST_IDLE);
        gen_rst_n_d  = (state_d != ST_IDLE);
        capture_en_d = (state_d == ST_CAPTURE);
    end

    assign start_ready_o = (state_q == ST_IDLE);
    assign gen_rst_no    = gen_rst_n_q;
    assign capture_en_o  = capture_en_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Randomized and directed sessions for i2s_capture_ctrl checked cycle by cycle against
// a per-session outcome prediction built from the frame/stop schedule.
module tb_i2s_capture_ctrl;

    localparam int CNT_W = 8;
    localparam int WARM  = 2;
    localparam int TMO   = 64;
    localparam int CMAX  = 255;
    localparam int L     = 700;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [CNT_W-1:0] start_frames;
    logic             stop;
    logic             frame_start;
    logic             gen_rst_n;
    logic             capture_en;
    logic [CNT_W-1:0] frame_cnt;
    logic             busy;
    logic             done;
    logic             err;

    i2s_capture_ctrl #(
        .CNT_W(CNT_W),
        .WARMUP_FRAMES(WARM),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .start_valid_i(start_valid),
        .start_ready_o(start_ready),
        .start_frames_i(start_frames),
        .stop_i(stop),
        .frame_start_i(frame_start),
        .gen_rst_no(gen_rst_n),
        .capture_en_o(capture_en),
        .frame_cnt_o(frame_cnt),
        .busy_o(busy),
        .done_o(done),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit fs [0:L];
    bit st [0:L];
    int exp_cnt [0:L];
    int last_cnt = 0;
    bit last_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ovec();
        return {27'd0, start_ready, busy, gen_rst_n, capture_en, done};
    endfunction

    task automatic clear_sched();
        for (int i = 0; i <= L; i++) begin
            fs[i] = 1'b0;
            st[i] = 1'b0;
            exp_cnt[i] = 0;
        end
    endtask

    // Walks the schedule edge by edge from the handshake (edge 0) and predicts the session outcome.
    task automatic run_model(input int tgt, output int e_end, output int m_cap, output bit e_err);
        int  warm, cnt, last;
        bit  in_cap, pend;
        warm = 0; cnt = 0; last = 0; in_cap = 0; pend = 0;
        e_end = -1; m_cap = -1; e_err = 1'b0;
        exp_cnt[0] = 0;
        for (int e = 1; e <= L; e++) begin
            if (!in_cap) begin
                if (st[e]) begin
                    e_end = e;
                end else if (fs[e]) begin
                    last = e;
                    warm++;
                    if (warm == WARM) begin
                        in_cap = 1'b1;
                        m_cap  = e;
                    end
                end else if (e - last == TMO) begin
                    e_end = e;
                    e_err = 1'b1;
                end
            end else begin
                if (fs[e]) begin
                    last = e;
                    if (cnt < CMAX) cnt++;
                    if ((tgt != 0 && cnt == tgt) || pend || st[e]) e_end = e;
                end else begin
                    if (st[e]) pend = 1'b1;
                    if (e - last == TMO) begin
                        e_end = e;
                        e_err = 1'b1;
                    end
                end
            end
            exp_cnt[e] = cnt;
            if (e_end >= 0) break;
        end
    endtask

    task automatic run_session(input int tgt, input bit hold);
        int e_end, m_cap;
        bit e_err;
        bit cap_exp;
        run_model(tgt, e_end, m_cap, e_err);
        if (e_end < 0) begin
            n_err++;
            $display("FAIL session_bound got=none exp=end_within_%0d", L);
            return;
        end
        start_valid  = 1'b1;
        start_frames = CNT_W'(tgt);
        frame_start  = 1'($urandom);
        stop         = 1'($urandom);
        for (int c = 0; c <= e_end; c++) begin
            if (c > 0) begin
                start_valid  = hold;
                start_frames = CNT_W'($urandom);
                frame_start  = fs[c];
                stop         = st[c];
            end
            step();
            cap_exp = (m_cap >= 0) && (c >= m_cap);
            if (c < e_end) begin
                check_eq("busy_outs", ovec(), {27'd0, 1'b0, 1'b1, 1'b1, cap_exp, 1'b0});
                check_eq("busy_err", 32'(err), 32'd0);
            end else begin
                check_eq("exit_outs", ovec(), {27'd0, 5'b10001});
                check_eq("exit_err", 32'(err), 32'(e_err));
            end
            check_eq("frame_cnt", 32'(frame_cnt), 32'(exp_cnt[c]));
        end
        start_valid = 1'b0;
        frame_start = 1'b0;
        stop        = 1'b0;
        last_cnt    = exp_cnt[e_end];
        last_err    = e_err;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start_valid = 1'b0;
            frame_start = 1'($urandom);
            stop        = 1'($urandom);
            step();
            check_eq("idle_outs", ovec(), {27'd0, 5'b10000});
            check_eq("idle_cnt", 32'(frame_cnt), 32'(last_cnt));
            check_eq("idle_err", 32'(err), 32'(last_err));
        end
        frame_start = 1'b0;
        stop        = 1'b0;
    endtask

    initial begin
        int t, np, tgt;
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        start_frames = '0;
        stop         = 1'b0;
        frame_start  = 1'b0;
        step();
        step();
        check_eq("reset_outs", ovec(), {27'd0, 5'b10000});
        check_eq("reset_cnt", 32'(frame_cnt), 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Fixed target of 3 frames
        clear_sched();
        for (int k = 1; k <= 5; k++) fs[4 * k] = 1'b1;
        run_session(3, 1'b0);
        idle_cycles(1);

        // Continuous, stop 10 cycles after the 4th captured pulse
        clear_sched();
        for (int k = 1; k <= 10; k++) fs[3 * k] = 1'b1;
        st[28] = 1'b1;
        run_session(0, 1'b1);

        // Stop coincident with a capture pulse, back-to-back with the previous session
        clear_sched();
        for (int k = 1; k <= 6; k++) fs[4 * k] = 1'b1;
        st[16] = 1'b1;
        run_session(0, 1'b0);
        idle_cycles(2);

        // Stop during warm-up
        clear_sched();
        fs[4] = 1'b1;
        st[6] = 1'b1;
        fs[9] = 1'b1;
        run_session(2, 1'b0);
        idle_cycles(1);

        // Frame pulses withheld until timeout
        clear_sched();
        for (int k = 1; k <= 4; k++) fs[4 * k] = 1'b1;
        run_session(0, 1'b0);
        idle_cycles(2);

        // Count saturation with err cleared by the new start
        clear_sched();
        for (int k = 1; k <= 260; k++) fs[2 * k] = 1'b1;
        st[519] = 1'b1;
        run_session(0, 1'b0);
        idle_cycles(1);

        for (int s = 0; s < 40; s++) begin
            clear_sched();
            tgt = $urandom_range(0, 6);
            np  = $urandom_range(3, 14);
            t   = 0;
            for (int i = 0; i < np; i++) begin
                if (s % 5 == 0 && i == 3) t += $urandom_range(TMO - 2, TMO + 2);
                else t += $urandom_range(1, 8);
                if (t <= L) fs[t] = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) st[$urandom_range(1, 100)] = 1'b1;
            run_session(tgt, 1'($urandom));
            idle_cycles($urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of a capture
        start_valid  = 1'b1;
        start_frames = 8'd0;
        step();
        start_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            frame_start = (c % 4 == 0);
            step();
        end
        frame_start = 1'b0;
        check_eq("pre_rst_cnt", 32'(frame_cnt), 32'd5);
        check_eq("pre_rst_outs", ovec(), {27'd0, 5'b01110});
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_outs", ovec(), {27'd0, 5'b10000});
        check_eq("async_rst_cnt", 32'(frame_cnt), 32'd0);
        check_eq("async_rst_err", 32'(err), 32'd0);
        step();
        check_eq("rst_hold_outs", ovec(), {27'd0, 5'b10000});
        rst_n    = 1'b1;
        last_cnt = 0;
        last_err = 1'b0;
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
